// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and the decode hazard unit:
// widths, source-select encoding, round-robin pointer encoding, write request.
package wb_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    // Which producer owns the write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_MDU  = 2'd3
    } src_e;

    // Round-robin pointer between the two long-latency producers.
    typedef enum logic {
        RR_LSU = 1'b0,
        RR_MDU = 1'b1
    } rr_e;

    // Destination/data pair carried by the winning producer.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // LSU and MDU writes retire scoreboard entries; ALU writes never do.
    function automatic logic is_long_src(input src_e s);
        return (s == SRC_LSU) || (s == SRC_MDU);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/decode side and register-file write port of the writeback arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            mdu_valid;
    logic            mdu_ready;
    logic [AW-1:0]   mdu_rd;
    logic [XLEN-1:0] mdu_data;

    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;

    logic [AW-1:0]   rd;
    logic            regwrite;
    logic [XLEN-1:0] rd_data;
    logic [NREG-1:0] pending;

    // Producers, decode and the register file together.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready,
        output issue_valid, issue_rd, flush,
        input  rd, regwrite, rd_data, pending
    );

    // The arbiter itself.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready,
        input  issue_valid, issue_rd, flush,
        output rd, regwrite, rd_data, pending
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write bit vector: one bit per architectural register that has an
// LSU/MDU result still in flight. x0 never pends.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_set_en,
    input  logic [AW-1:0]   i_set_idx,
    input  logic            i_clr_en,
    input  logic [AW-1:0]   i_clr_idx,
    input  logic            i_flush,
    output logic [NREG-1:0] o_pending
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_nxt;

    // Next state: clear first, then set, so a new issue to the same register
    // that is retiring this cycle stays outstanding. Flush wins over both.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_en) w_set[i_set_idx] = 1'b1;
        if (i_clr_en) w_clr[i_clr_idx] = 1'b1;
        w_nxt = i_flush ? '0 : ((r_pend & ~w_clr) | w_set);
        w_nxt[0] = 1'b0;
    end

    // Pending bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pend <= '0;
        else        r_pend <= w_nxt;
    end

    assign o_pending = r_pend;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU has fixed priority, LSU/MDU share the remaining
// slots round-robin. The winner is registered onto the register-file write
// port one cycle after acceptance; the port never stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    src_e            w_src;
    wb_req_t         w_win;
    rr_e             r_rr;
    rr_e             w_rr_nxt;

    logic            r_regwrite;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_data;

    // Grant selection; ALU is always accepted so it preempts both long sources.
    always_comb begin
        w_src = SRC_NONE;
        w_win = '0;
        if (bus.alu_valid) begin
            w_src = SRC_ALU;
        end else if (bus.lsu_valid && bus.mdu_valid) begin
            w_src = (r_rr == RR_LSU) ? SRC_LSU : SRC_MDU;
        end else if (bus.lsu_valid) begin
            w_src = SRC_LSU;
        end else if (bus.mdu_valid) begin
            w_src = SRC_MDU;
        end
        case (w_src)
            SRC_ALU: w_win = '{rd: bus.alu_rd, data: bus.alu_data};
            SRC_LSU: w_win = '{rd: bus.lsu_rd, data: bus.lsu_data};
            SRC_MDU: w_win = '{rd: bus.mdu_rd, data: bus.mdu_data};
            default: w_win = '0;
        endcase
    end

    // Ready goes only to a valid winner and is suppressed while in reset.
    assign bus.lsu_ready = rst_n && (w_src == SRC_LSU);
    assign bus.mdu_ready = rst_n && (w_src == SRC_MDU);

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rr <= RR_LSU;
        else        r_rr <= w_rr_nxt;
    end

    // Pointer hands priority to the other long source after each grant to one.
    always_comb begin
        w_rr_nxt = r_rr;
        case (w_src)
            SRC_LSU: w_rr_nxt = RR_MDU;
            SRC_MDU: w_rr_nxt = RR_LSU;
            default: w_rr_nxt = r_rr;
        endcase
    end

    // Output stage; x0 writes complete the handshake but never assert
    // regwrite, and rd/rd_data hold their last real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
        end else if (w_src != SRC_NONE && w_win.rd != '0) begin
            r_regwrite <= 1'b1;
            r_rd       <= w_win.rd;
            r_data     <= w_win.data;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign bus.regwrite = r_regwrite;
    assign bus.rd       = r_rd;
    assign bus.rd_data  = r_data;

    wb_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (bus.issue_valid),
        .i_set_idx (bus.issue_rd),
        .i_clr_en  (is_long_src(w_src)),
        .i_clr_idx (w_win.rd),
        .i_flush   (bus.flush),
        .o_pending (bus.pending)
    );

endmodule
